// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 encryption stream controller.
//   AES_BLOCK_W           : data/key width of the AES_enc core.
//   AES128_KEY_EXP_CYCLES : core key-expansion time after fsm_en.
//   ctrl_state_t          : controller state encoding.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W           = 128;
  localparam int unsigned AES128_KEY_EXP_CYCLES = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEY_EXP,
    ST_RUN,
    ST_DRAIN
  } ctrl_state_t;

endpackage

// File: rtl/aes_out_fifo.sv
// Synchronous ciphertext FIFO with occupancy count.
// Ports:
//   clk, rst (async, active-low)
//   wr_en/wr_data : push; dropped when full (flagged on overflow)
//   rd_en         : pop request; ignored when empty
//   rd_data       : head entry, zero while empty
//   empty, count  : status
//   overflow      : push attempted while full (combinational)
module aes_out_fifo
  import aes_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = AES_BLOCK_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             wr_ok;
  logic             rd_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign wr_ok    = wr_en && !full;
  assign rd_ok    = rd_en && !empty;
  assign overflow = wr_en && full;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/aes_enc_stream_ctrl.sv
// Streaming controller around an AES_enc core (no backpressure on the core).
// Ports:
//   clk, rst (async, active-low)
//   key_load/key/key_ready            : key load handshake
//   s_valid/s_ready/s_data            : plaintext stream in
//   m_valid/m_ready/m_data            : ciphertext stream out
//   core_in/core_key/core_enable/core_fsm_en/core_out/core_valid_out : core drive
//   busy    : not IDLE/RUN, or blocks still accounted for
//   err_ovf : sticky; unexpected core output or FIFO overflow
module aes_enc_stream_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned KEY_EXP_CYCLES = AES128_KEY_EXP_CYCLES,
  parameter int unsigned FIFO_DEPTH     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key,
  output logic         key_ready,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic [127:0] core_in,
  output logic [127:0] core_key,
  output logic         core_enable,
  output logic         core_fsm_en,
  input  logic [127:0] core_out,
  input  logic         core_valid_out,
  output logic         busy,
  output logic         err_ovf
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned KW = (KEY_EXP_CYCLES > 0) ? $clog2(KEY_EXP_CYCLES + 1) : 1;

  ctrl_state_t      state;
  ctrl_state_t      state_nxt;
  logic [KW-1:0]    kexp_cnt;
  logic             kexp_done;
  logic [127:0]     key_reg;
  logic [127:0]     pend_key;
  logic [CW-1:0]    credits;
  logic [CW-1:0]    fifo_count;
  logic [CW-1:0]    in_flight;
  logic             fifo_empty;
  logic             fifo_ovf;
  logic             rst_done;
  logic             transfer;
  logic             pop;
  logic             push;
  logic             drain_done;

  assign kexp_done  = (kexp_cnt == KW'(KEY_EXP_CYCLES));
  // FIFO entries are a subset of credits, so the difference is what the core still holds.
  assign in_flight  = credits - fifo_count;
  assign drain_done = (state == ST_DRAIN) && (in_flight == '0);
  assign transfer   = s_valid && s_ready;
  assign m_valid    = !fifo_empty;
  assign pop        = m_valid && m_ready;
  assign push       = core_valid_out && (in_flight != '0);
  assign core_key   = key_reg;
  assign busy       = ((state != ST_IDLE) && (state != ST_RUN)) || (credits != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    key_ready   = 1'b0;
    s_ready     = 1'b0;
    core_fsm_en = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // rst_done keeps key_ready low while reset is asserted.
        key_ready = rst_done;
        if (key_load && rst_done) state_nxt = ST_KEY_EXP;
      end
      ST_KEY_EXP: begin
        core_fsm_en = (kexp_cnt == '0);
        if (kexp_done) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        key_ready = 1'b1;
        s_ready   = (credits < CW'(FIFO_DEPTH)) && !key_load;
        if (key_load) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (in_flight == '0) state_nxt = ST_KEY_EXP;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_done    <= 1'b0;
      kexp_cnt    <= '0;
      key_reg     <= '0;
      pend_key    <= '0;
      core_in     <= '0;
      core_enable <= 1'b0;
      credits     <= '0;
      err_ovf     <= 1'b0;
    end else begin
      rst_done <= 1'b1;

      if (state != ST_KEY_EXP) kexp_cnt <= '0;
      else if (!kexp_done)     kexp_cnt <= kexp_cnt + 1'b1;

      if ((state == ST_IDLE) && key_load && key_ready) key_reg <= key;
      else if (drain_done)                             key_reg <= pend_key;

      if ((state == ST_RUN) && key_load) pend_key <= key;

      core_enable <= transfer;
      if (transfer) core_in <= s_data;

      case ({transfer, pop})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: ;
      endcase

      if ((core_valid_out && (in_flight == '0)) || fifo_ovf) err_ovf <= 1'b1;
    end
  end

  aes_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AES_BLOCK_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (push),
    .wr_data  (core_out),
    .rd_en    (m_ready),
    .rd_data  (m_data),
    .empty    (fifo_empty),
    .overflow (fifo_ovf),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_aes_enc_stream_ctrl.sv
// Directed bench for aes_enc_stream_ctrl with a stand-in AES core:
// fixed 4-cycle pipeline, FIPS-197 vectors for key K1, and a reversible
// XOR mapping for every other (block, key) pair.
module tb_aes_enc_stream_ctrl;

  localparam logic [127:0] K1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] K2 = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] P1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] C1 = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
  localparam logic [127:0] C2 = 128'hC6A13B37878F5B826F4F8162A1C8D879;

  logic         clk;
  logic         rst;
  logic         key_load;
  logic [127:0] key;
  logic         key_ready;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_data;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;
  logic [127:0] core_in;
  logic [127:0] core_key;
  logic         core_enable;
  logic         core_fsm_en;
  logic [127:0] core_out;
  logic         core_valid_out;
  logic         busy;
  logic         err_ovf;
  logic         inject;

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;
  int unsigned fsm_cnt = 0;
  logic [127:0] got [$];

  aes_enc_stream_ctrl #(
    .KEY_EXP_CYCLES (11),
    .FIFO_DEPTH     (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .key_load       (key_load),
    .key            (key),
    .key_ready      (key_ready),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .core_in        (core_in),
    .core_key       (core_key),
    .core_enable    (core_enable),
    .core_fsm_en    (core_fsm_en),
    .core_out       (core_out),
    .core_valid_out (core_valid_out),
    .busy           (busy),
    .err_ovf        (err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] k);
    if (k == K1 && pt == P1)    return C1;
    if (k == K1 && pt == '0)    return C2;
    return pt ^ {k[63:0], k[127:64]} ^ 128'hA5A5A5A5_5A5A5A5A_3C3C3C3C_C3C3C3C3;
  endfunction

  function automatic logic [127:0] blk(input int unsigned grp, input int unsigned n);
    return {32'hC0DE0000 + grp, 32'h00001000 + n, 32'h55550000 ^ n, 32'h0BADF00D + grp * 7 + n};
  endfunction

  // Stand-in core: the key is taken when the block leaves the pipeline.
  logic [3:0]   vpipe;
  logic [127:0] dpipe [4];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpipe <= '0;
      for (int i = 0; i < 4; i++) dpipe[i] <= '0;
    end else begin
      vpipe    <= {vpipe[2:0], core_enable};
      dpipe[0] <= core_in;
      for (int i = 1; i < 4; i++) dpipe[i] <= dpipe[i-1];
    end
  end
  assign core_out       = enc(dpipe[3], core_key);
  assign core_valid_out = vpipe[3] | inject;

  // Inputs change 1 time unit after posedge, so negedge sees the values the next edge acts on.
  always @(negedge clk) begin
    if (rst && m_valid && m_ready) got.push_back(m_data);
    if (core_fsm_en) fsm_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_load = 1'b1;
    key      = k;
    check("load_key_ready", 128'(key_ready), 128'(1'b1));
    tick();
    key_load = 1'b0;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 60 && s_ready !== 1'b1; i++) tick();
    check("wait_run", 128'(s_ready), 128'(1'b1));
  endtask

  task automatic send_block(input logic [127:0] d);
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 100 && s_ready !== 1'b1; i++) tick();
    check("send_ready", 128'(s_ready), 128'(1'b1));
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_got(input int unsigned n);
    for (int i = 0; i < 300 && got.size() < n; i++) tick();
    check("wait_got", 128'(got.size() >= n), 128'(1'b1));
  endtask

  initial begin
    int unsigned base;
    int unsigned n;
    int unsigned en_hi;
    int unsigned fc0;

    rst = 1'b1; key_load = 1'b0; key = '0; s_valid = 1'b0; s_data = '0;
    m_ready = 1'b0; inject = 1'b0;
    #1 rst = 1'b0;
    #1;
    // Reset values
    check("rst_key_ready",   128'(key_ready),   '0);
    check("rst_s_ready",     128'(s_ready),     '0);
    check("rst_m_valid",     128'(m_valid),     '0);
    check("rst_busy",        128'(busy),        '0);
    check("rst_err_ovf",     128'(err_ovf),     '0);
    check("rst_core_enable", 128'(core_enable), '0);
    check("rst_core_fsm_en", 128'(core_fsm_en), '0);
    check("rst_core_in",     core_in,           '0);
    check("rst_core_key",    core_key,          '0);
    check("rst_m_data",      m_data,            '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    check("key_ready_pre", 128'(key_ready), '0);
    tick();
    check("key_ready_rise", 128'(key_ready), 128'(1'b1));
    check("idle_s_ready",   128'(s_ready),   '0);

    // Basic: key expansion timing and first block
    load_key(K1);
    check("kexp_fsm_en",    128'(core_fsm_en), 128'(1'b1));
    check("kexp_core_key",  core_key,          K1);
    check("kexp_key_ready", 128'(key_ready),   '0);
    check("kexp_busy",      128'(busy),        128'(1'b1));
    tick();
    check("kexp_fsm_en_once", 128'(core_fsm_en), '0);
    repeat (10) tick();
    check("kexp_last_s_ready", 128'(s_ready), '0);
    tick();
    check("run_s_ready", 128'(s_ready), 128'(1'b1));
    base = got.size();
    send_block(P1);
    for (int i = 0; i < 20 && core_valid_out !== 1'b1; i++) tick();
    check("core_valid_seen", 128'(core_valid_out), 128'(1'b1));
    check("fwft_before", 128'(m_valid), '0);
    tick();
    check("fwft_m_valid", 128'(m_valid), 128'(1'b1));
    check("basic_m_data", m_data, C1);
    tick();
    check("basic_hold",   m_data, C1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("basic_popped", 128'(m_valid), '0);
    check("basic_got",    got[base], C1);
    check("basic_idle_busy", 128'(busy), '0);

    // Back-to-back: 11 consecutive blocks
    m_ready = 1'b1;
    base = got.size();
    en_hi = 0;
    s_valid = 1'b1;
    for (int unsigned i = 0; i < 11; i++) begin
      s_data = (i == 0) ? P1 : (i == 1) ? 128'h0 : blk(1, i);
      check("b2b_s_ready", 128'(s_ready), 128'(1'b1));
      tick();
      if (core_enable === 1'b1) en_hi++;
    end
    s_valid = 1'b0;
    tick();
    check("b2b_enable_run", 128'(en_hi), 128'(11));
    check("b2b_enable_end", 128'(core_enable), '0);
    wait_got(base + 11);
    check("b2b_first",  got[base],     C1);
    check("b2b_second", got[base + 1], C2);
    for (int unsigned i = 2; i < 11; i++)
      check("b2b_order", got[base + i], enc(blk(1, i), K1));

    // Backpressure: exactly FIFO_DEPTH transfers, then full drain in order
    m_ready = 1'b0;
    base = got.size();
    n = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      s_data = blk(2, n);
      if (s_ready === 1'b1) n++;
      tick();
    end
    s_valid = 1'b0;
    check("bp_transfers", 128'(n), 128'(16));
    check("bp_s_ready",   128'(s_ready), '0);
    check("bp_head",      m_data, enc(blk(2, 0), K1));
    check("bp_err",       128'(err_ovf), '0);
    m_ready = 1'b1;
    wait_got(base + 16);
    for (int unsigned i = 0; i < 16; i++)
      check("bp_order", got[base + i], enc(blk(2, i), K1));
    check("bp_err_after", 128'(err_ovf), '0);

    // Simultaneous pop and offer at credits == FIFO_DEPTH
    m_ready = 1'b0;
    base = got.size();
    n = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      s_data = blk(3, n);
      if (s_ready === 1'b1) n++;
      tick();
    end
    check("sp_fill", 128'(n), 128'(16));
    s_data  = blk(3, 16);
    m_ready = 1'b1;
    check("sp_full_s_ready", 128'(s_ready), '0);
    tick();
    m_ready = 1'b0;
    check("sp_after_pop_s_ready", 128'(s_ready), 128'(1'b1));
    tick();
    s_valid = 1'b0;
    check("sp_cap_s_ready", 128'(s_ready), '0);
    m_ready = 1'b1;
    wait_got(base + 17);
    for (int unsigned i = 0; i < 17; i++)
      check("sp_order", got[base + i], enc(blk(3, i), K1));
    check("sp_err", 128'(err_ovf), '0);

    // Key change while streaming
    base = got.size();
    fc0 = fsm_cnt;
    s_valid = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      s_data = blk(4, i);
      check("kc_s_ready", 128'(s_ready), 128'(1'b1));
      tick();
    end
    s_data   = blk(4, 4);
    key_load = 1'b1;
    key      = K2;
    #1;
    check("kc_load_s_ready",   128'(s_ready),   '0);
    check("kc_load_key_ready", 128'(key_ready), 128'(1'b1));
    tick();
    key_load = 1'b0;
    s_valid  = 1'b0;
    check("drain_key_ready", 128'(key_ready), '0);
    check("drain_old_key",   core_key, K1);
    check("drain_busy",      128'(busy), 128'(1'b1));
    for (int i = 0; i < 50 && core_fsm_en !== 1'b1; i++) tick();
    check("kc_fsm_en_seen", 128'(core_fsm_en), 128'(1'b1));
    check("kc_new_key",     core_key, K2);
    check("kc_drained",     128'(got.size() - base), 128'(4));
    wait_run();
    check("kc_fsm_pulses", 128'(fsm_cnt - fc0), 128'(1));
    for (int unsigned i = 0; i < 4; i++)
      check("kc_old_key_ct", got[base + i], enc(blk(4, i), K1));
    send_block(blk(4, 5));
    wait_got(base + 5);
    check("kc_new_key_ct", got[base + 4], enc(blk(4, 5), K2));

    // Reset with 5 blocks in flight
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      s_data = blk(5, i);
      check("rs_s_ready", 128'(s_ready), 128'(1'b1));
      tick();
    end
    s_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rs_m_valid",     128'(m_valid),     '0);
    check("rs_s_ready_low", 128'(s_ready),     '0);
    check("rs_busy",        128'(busy),        '0);
    check("rs_core_enable", 128'(core_enable), '0);
    check("rs_core_key",    core_key,          '0);
    tick();
    rst = 1'b1;
    base = got.size();
    tick();
    check("rs_key_ready", 128'(key_ready), 128'(1'b1));
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = blk(5, 9);
    repeat (5) tick();
    check("rs_idle_s_ready", 128'(s_ready), '0);
    check("rs_no_output",    128'(m_valid), '0);
    s_valid = 1'b0;
    load_key(K1);
    wait_run();
    send_block(P1);
    wait_got(base + 1);
    check("rs_restart_ct", got[base], C1);
    repeat (8) tick();
    check("rs_no_stale", 128'(got.size() - base), 128'(1));
    check("rs_err",      128'(err_ovf), '0);

    // Core output with nothing in flight is dropped and flagged
    inject = 1'b1;
    tick();
    inject = 1'b0;
    check("inj_err_ovf", 128'(err_ovf), 128'(1'b1));
    tick();
    check("inj_m_valid", 128'(m_valid), '0);
    rst = 1'b0;
    #1;
    check("inj_err_cleared", 128'(err_ovf), '0);
    rst = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/aes_enc_stream_ctrl.md
AES_ENC_STREAM_CTRL -- requirements
Module: aes_enc_stream_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- KEY_EXP_CYCLES, 11, core key-expansion time after the fsm_en pulse.
- FIFO_DEPTH, 16, output buffer entries; power of two, at least 2.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- rst, in, 1, reset, asynchronous, active-low.
- key_load, in, 1, load request for a new key.
- key, in, 128, cipher key; sampled when key_load && key_ready.
- key_ready, out, 1, controller can accept a key load.
- s_valid, in, 1, plaintext valid.
- s_ready, out, 1, plaintext accepted this cycle.
- s_data, in, 128, plaintext block.
- m_valid, out, 1, ciphertext valid.
- m_ready, in, 1, downstream accepts ciphertext.
- m_data, out, 128, ciphertext block.
- core_in, out, 128, to AES_enc IN.
- core_key, out, 128, to AES_enc KEY.
- core_enable, out, 1, to AES_enc enable.
- core_fsm_en, out, 1, to AES_enc fsm_en.
- core_out, in, 128, from AES_enc OUT.
- core_valid_out, in, 1, from AES_enc valid_out.
- busy, out, 1, high when the state is not IDLE or RUN, or when credits are nonzero.
- err_ovf, out, 1, sticky overflow error flag.

Function
REQ-003 State machine with states IDLE, KEY_EXP, RUN and DRAIN; reset state is IDLE.
REQ-004 IDLE: key_ready=1, s_ready=0; key_load moves to KEY_EXP.
REQ-005 Key capture: key_load && key_ready latches key into a key register that drives core_key.
REQ-006 KEY_EXP timing:
- core_fsm_en=1 for exactly the first cycle in KEY_EXP.
- The state then holds for KEY_EXP_CYCLES further cycles (total KEY_EXP_CYCLES+1), then moves to RUN.
- key_ready=0 and s_ready=0 throughout.
REQ-007 RUN, handshakes and core drive:
- key_ready=1.
- s_ready = (credits < FIFO_DEPTH) && !key_load.
- A transfer occurs when s_valid && s_ready.
- core_in is registered s_data; core_enable is registered transfer, asserted the cycle after the transfer.
REQ-008 Credit counter, width clog2(FIFO_DEPTH+1):
- Counts blocks in flight in the core plus blocks held in the FIFO.
- +1 on an input transfer; -1 on an output pop (m_valid && m_ready).
- Unchanged when both happen in the same cycle.
- Never exceeds FIFO_DEPTH; this guarantees the core, which has no backpressure, never outputs into a full FIFO.
REQ-009 Output FIFO:
- core_valid_out writes core_out into the FIFO.
- m_valid = FIFO not empty; m_data = head entry, stable while m_valid && !m_ready.
- First-word latency: m_valid asserts the cycle after core_valid_out.
- Ciphertext order equals plaintext order.
REQ-010 FIFO pointers wrap modulo FIFO_DEPTH.
- Simultaneous write and pop when full or empty behave as separate push and pop.
- A push to a full FIFO is dropped and sets err_ovf.
REQ-011 Key change in RUN: key_load in RUN moves to DRAIN; the new key is captured in the same cycle into a pending-key register.
REQ-012 DRAIN:
- s_ready=0, key_ready=0.
- core_key keeps the old key until the in-flight count (credits minus FIFO occupancy) reaches 0.
- At that point the pending key is applied and the state moves to KEY_EXP.
- FIFO contents remain poppable throughout.
REQ-013 core_valid_out while the in-flight count is 0 is ignored and sets err_ovf.
REQ-014 No combinational path from s_valid to s_ready; m_ready may combinationally affect only FIFO pop logic.

Reset
REQ-015 On rst=0, asynchronously:
- State goes to IDLE.
- Credits, FIFO pointers and occupancy go to 0.
- Outputs go to: core_enable=0, core_fsm_en=0, m_valid=0, s_ready=0, key_ready=0, busy=0, err_ovf=0, core_in=0, core_key=0, m_data=0.
REQ-016 key_ready rises the first cycle after rst deasserts.
REQ-017 Reset mid-operation discards in-flight and buffered blocks; a key load is required before any new data is accepted.

Structure
REQ-018 Shared package aes_pkg holds:
- The state enum.
- AES_BLOCK_W=128 and AES128_KEY_EXP_CYCLES=11.
REQ-019 One sub-module, aes_out_fifo: synchronous FIFO of width 128 and depth FIFO_DEPTH, with count output; all other logic is in the top module.

Verification
REQ-020 Directed scenarios a bench must cover:
- Basic: key 000102030405060708090A0B0C0D0E0F loaded; after KEY_EXP_CYCLES+1 cycles s_ready=1; s_data 00112233445566778899AABBCCDDEEFF -> m_data 69C4E0D86A7B0430D8CDB78070B4C55A.
- Back-to-back: same key, 11 consecutive blocks, second block 00000000000000000000000000000000 -> outputs in order, second is C6A13B37878F5B826F4F8162A1C8D879; core_enable high for 11 consecutive cycles.
- Backpressure: m_ready=0 with continuous s_valid -> exactly FIFO_DEPTH transfers, then s_ready=0; releasing m_ready drains all 16 in order; err_ovf stays 0.
- Key change: key_load during streaming -> DRAIN; old-key ciphertexts still correct; core_fsm_en pulses once only after in-flight reaches 0; new-key results correct.
- Reset mid-stream: rst=0 with 5 blocks in flight -> m_valid=0 immediately; s_ready=0 until a new key load completes; no stale outputs after restart.
- Simultaneous push/pop: credits==FIFO_DEPTH with pop and input offered in the same cycle -> s_ready=0 that cycle and 1 the next; credits never exceed 16.
